// File: rtl/request_unit_fsm_if.sv
// Memory-request handshake between the request sequencer and the datapath/cache side.
// The sequencer is the master; the datapath/cache side is the slave.
interface request_unit_fsm_if;
    logic ihit;
    logic dhit;
    logic dRENi;
    logic dWENi;
    logic halt_i;
    logic imemREN;
    logic dmemREN;
    logic dmemWEN;
    logic pcEN;
    logic halt;

    modport master (
        input  ihit, dhit, dRENi, dWENi, halt_i,
        output imemREN, dmemREN, dmemWEN, pcEN, halt
    );

    modport slave (
        output ihit, dhit, dRENi, dWENi, halt_i,
        input  imemREN, dmemREN, dmemWEN, pcEN, halt
    );
endinterface

// File: rtl/request_unit_fsm.sv
// Memory-request sequencer: one outstanding request at a time, sticky halt,
// and saturating retired-instruction / stall-cycle counters.
module request_unit_fsm #(
    parameter int CNTW = 32
) (
    input  logic                CLK,
    input  logic                nRST,
    request_unit_fsm_if.master  ruif,
    output logic [CNTW-1:0]     instr_cnt,
    output logic [CNTW-1:0]     stall_cnt
);

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        DATA   = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t state, state_n;
    logic   imem_n, dren_n, dwen_n, halt_n;
    logic   retire, stall;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state        <= FETCH;
            ruif.imemREN <= 1'b1;
            ruif.dmemREN <= 1'b0;
            ruif.dmemWEN <= 1'b0;
            ruif.halt    <= 1'b0;
        end else begin
            state        <= state_n;
            ruif.imemREN <= imem_n;
            ruif.dmemREN <= dren_n;
            ruif.dmemWEN <= dwen_n;
            ruif.halt    <= halt_n;
        end
    end

    always_comb begin
        state_n = state;
        imem_n  = ruif.imemREN;
        dren_n  = ruif.dmemREN;
        dwen_n  = ruif.dmemWEN;
        halt_n  = ruif.halt;
        retire  = 1'b0;
        stall   = 1'b0;
        case (state)
            FETCH: begin
                if (ruif.ihit) begin
                    if (ruif.halt_i) begin
                        state_n = HALTED;
                        halt_n  = 1'b1;
                        imem_n  = 1'b0;
                    end else if (ruif.dRENi || ruif.dWENi) begin
                        // Store wins when the decoder flags both.
                        state_n = DATA;
                        imem_n  = 1'b0;
                        dren_n  = ruif.dRENi & ~ruif.dWENi;
                        dwen_n  = ruif.dWENi;
                    end else begin
                        retire = 1'b1;
                    end
                end else begin
                    stall = 1'b1;
                end
            end
            DATA: begin
                if (ruif.dhit) begin
                    retire  = 1'b1;
                    state_n = FETCH;
                    imem_n  = 1'b1;
                    dren_n  = 1'b0;
                    dwen_n  = 1'b0;
                end else begin
                    stall = 1'b1;
                end
            end
            HALTED: begin
                imem_n = 1'b0;
                dren_n = 1'b0;
                dwen_n = 1'b0;
                halt_n = 1'b1;
            end
            default: begin
                state_n = FETCH;
                imem_n  = 1'b1;
                dren_n  = 1'b0;
                dwen_n  = 1'b0;
                halt_n  = 1'b0;
            end
        endcase
    end

    assign ruif.pcEN = retire & nRST;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            instr_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            if (retire && !(&instr_cnt))
                instr_cnt <= instr_cnt + CNTW'(1);
            if (stall && !(&stall_cnt))
                stall_cnt <= stall_cnt + CNTW'(1);
        end
    end

endmodule

// File: tb/tb_request_unit_fsm.sv
// Directed bench for request_unit_fsm: per-cycle comparison against a behavioural
// model, literal spot checks, and a CNTW=4 instance for counter saturation.
module tb_request_unit_fsm;

    logic        CLK;
    logic        nRST;
    logic [31:0] instr_cnt, stall_cnt;
    logic [3:0]  instr_cnt4, stall_cnt4;

    request_unit_fsm_if ruif();
    request_unit_fsm_if ruif4();

    request_unit_fsm #(.CNTW(32)) dut (
        .CLK       (CLK),
        .nRST      (nRST),
        .ruif      (ruif.master),
        .instr_cnt (instr_cnt),
        .stall_cnt (stall_cnt)
    );

    request_unit_fsm #(.CNTW(4)) dut4 (
        .CLK       (CLK),
        .nRST      (nRST),
        .ruif      (ruif4.master),
        .instr_cnt (instr_cnt4),
        .stall_cnt (stall_cnt4)
    );

    int checks = 0;
    int errors = 0;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: is the machine halted, which data access (if any) is pending, and the counts.
    bit          m_halted;
    int          m_pend;      // 0 none, 1 load pending, 2 store pending
    logic [31:0] m_ic, m_sc;

    initial begin
        m_halted = 0; m_pend = 0; m_ic = '0; m_sc = '0;
    end

    always @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            m_halted = 0; m_pend = 0; m_ic = '0; m_sc = '0;
        end else if (!m_halted) begin
            if (m_pend == 0) begin
                if (ruif.ihit) begin
                    if (ruif.halt_i)      m_halted = 1;
                    else if (ruif.dWENi)  m_pend = 2;
                    else if (ruif.dRENi)  m_pend = 1;
                    else if (m_ic != 32'hFFFF_FFFF) m_ic = m_ic + 1;
                end else if (m_sc != 32'hFFFF_FFFF) m_sc = m_sc + 1;
            end else begin
                if (ruif.dhit) begin
                    m_pend = 0;
                    if (m_ic != 32'hFFFF_FFFF) m_ic = m_ic + 1;
                end else if (m_sc != 32'hFFFF_FFFF) m_sc = m_sc + 1;
            end
        end
    end

    logic exp_pc;
    always @(negedge CLK) begin
        if (!nRST || m_halted)  exp_pc = 1'b0;
        else if (m_pend == 0)   exp_pc = ruif.ihit & ~ruif.halt_i & ~ruif.dRENi & ~ruif.dWENi;
        else                    exp_pc = ruif.dhit;
        chk("imemREN", {31'd0, ruif.imemREN}, {31'd0, !m_halted && m_pend == 0});
        chk("dmemREN", {31'd0, ruif.dmemREN}, {31'd0, m_pend == 1});
        chk("dmemWEN", {31'd0, ruif.dmemWEN}, {31'd0, m_pend == 2});
        chk("halt",    {31'd0, ruif.halt},    {31'd0, m_halted});
        chk("pcEN",    {31'd0, ruif.pcEN},    {31'd0, exp_pc});
        chk("instr_cnt", instr_cnt, m_ic);
        chk("stall_cnt", stall_cnt, m_sc);
        chk("req_excl", {31'd0, ruif.imemREN & (ruif.dmemREN | ruif.dmemWEN)}, 32'd0);
    end

    task automatic step(input logic ih, input logic dh, input logic r, input logic w, input logic h);
        ruif.ihit = ih; ruif.dhit = dh; ruif.dRENi = r; ruif.dWENi = w; ruif.halt_i = h;
        @(posedge CLK);
        #2;
    endtask

    initial begin
        ruif.ihit = 0; ruif.dhit = 0; ruif.dRENi = 0; ruif.dWENi = 0; ruif.halt_i = 0;
        ruif4.ihit = 0; ruif4.dhit = 0; ruif4.dRENi = 0; ruif4.dWENi = 0; ruif4.halt_i = 0;
        nRST = 1'b1;
        #1 nRST = 1'b0;
        repeat (3) @(posedge CLK);
        #2;
        chk("rst_instr", instr_cnt, 32'd0);
        chk("rst_stall", stall_cnt, 32'd0);
        chk("rst_imem",  {31'd0, ruif.imemREN}, 32'd1);
        chk("rst_halt",  {31'd0, ruif.halt}, 32'd0);
        nRST = 1'b1;

        // Three ALU instructions back to back
        repeat (3) step(1, 0, 0, 0, 0);
        chk("alu_instr", instr_cnt, 32'd3);
        chk("alu_stall", stall_cnt, 32'd0);

        // Load with two wait cycles
        step(1, 0, 1, 0, 0);
        chk("ld_dren", {31'd0, ruif.dmemREN}, 32'd1);
        chk("ld_imem", {31'd0, ruif.imemREN}, 32'd0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        chk("ld_instr", instr_cnt, 32'd4);
        chk("ld_stall", stall_cnt, 32'd2);
        chk("ld_back",  {31'd0, ruif.imemREN}, 32'd1);

        // Stray dhit in FETCH, then store with both strobes set
        step(0, 1, 0, 0, 0);
        step(1, 0, 1, 1, 0);
        chk("st_dwen", {31'd0, ruif.dmemWEN}, 32'd1);
        chk("st_dren", {31'd0, ruif.dmemREN}, 32'd0);
        step(0, 1, 0, 0, 0);
        chk("st_instr", instr_cnt, 32'd5);
        chk("st_stall", stall_cnt, 32'd3);

        // Reset while a store is in flight
        step(1, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0);
        chk("mid_pre_wen", {31'd0, ruif.dmemWEN}, 32'd1);
        nRST = 1'b0;
        #1;
        chk("mid_wen",   {31'd0, ruif.dmemWEN}, 32'd0);
        chk("mid_imem",  {31'd0, ruif.imemREN}, 32'd1);
        chk("mid_instr", instr_cnt, 32'd0);
        ruif.ihit = 1;
        #1;
        chk("mid_pcen", {31'd0, ruif.pcEN}, 32'd0);
        repeat (2) @(posedge CLK);
        #2;
        nRST = 1'b1;
        step(1, 0, 0, 0, 0);
        chk("post_instr", instr_cnt, 32'd1);
        chk("post_imem",  {31'd0, ruif.imemREN}, 32'd1);

        // HALT is sticky and freezes counters
        step(1, 0, 0, 0, 1);
        chk("hlt_halt", {31'd0, ruif.halt}, 32'd1);
        chk("hlt_imem", {31'd0, ruif.imemREN}, 32'd0);
        step(1, 1, 0, 0, 0);
        step(0, 1, 1, 0, 0);
        step(0, 0, 0, 0, 0);
        chk("hlt_instr", instr_cnt, 32'd1);
        chk("hlt_stall", stall_cnt, 32'd0);
        chk("hlt_sticky", {31'd0, ruif.halt}, 32'd1);

        // Saturation on the narrow instance, ihit held low
        ruif.ihit = 0; ruif.dhit = 0;
        nRST = 1'b0;
        @(posedge CLK);
        #2;
        nRST = 1'b1;
        repeat (20) @(posedge CLK);
        #2;
        chk("sat_stall4", {28'd0, stall_cnt4}, 32'd15);
        chk("sat_stall32", stall_cnt, 32'd20);
        repeat (5) @(posedge CLK);
        #2;
        chk("sat_hold4", {28'd0, stall_cnt4}, 32'd15);
        chk("sat_instr4", {28'd0, instr_cnt4}, 32'd0);
        chk("sat_stall32b", stall_cnt, 32'd25);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
